// File: rtl/udp_rx_frame_assembler.sv
// Assembles USER_DATA_BYTES payload bytes from a UDP byte stream into a flat frame
// register and hands it to the NN side with a one-cycle FRAME_READY pulse.
`timescale 1ns/1ps
module udp_rx_frame_assembler #(
    parameter int USER_DATA_BYTES = 784
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [7:0]                     RX_TDATA,
    input  logic                           RX_TVALID,
    input  logic                           RX_TLAST,
    output logic                           RX_TREADY,
    input  logic [31:0]                    RX_SRC_IP,
    input  logic [47:0]                    RX_SRC_MAC,
    input  logic [15:0]                    RX_SRC_UDP_PORT,
    input  logic                           NN_BUSY,
    output logic [0:USER_DATA_BYTES*8-1]   DATA_FRAME_IP,
    output logic [0:31]                    SRC_IP_ADDRESS_IP,
    output logic [0:47]                    SRC_MAC_ADDRESS_IP,
    output logic [0:15]                    SRC_UDP_PORT_IP,
    output logic                           FRAME_READY,
    output logic [15:0]                    FRAME_COUNT,
    output logic [15:0]                    DROP_COUNT
);

    localparam logic [15:0] LAST_IDX = 16'(USER_DATA_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        DISCARD,
        PENDING,
        EMIT
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] byte_cnt_reg;
    logic [15:0] frame_cnt_reg;
    logic [15:0] drop_cnt_reg;
    logic [31:0] src_ip_reg;
    logic [47:0] src_mac_reg;
    logic [15:0] src_port_reg;

    logic        beat;
    logic        wr_en;
    logic        hdr_en;
    logic        cnt_load;
    logic        cnt_inc;
    logic        drop_inc;
    logic [15:0] wr_idx;

    // Ready is gated by reset so the upstream never sees a beat accepted while held in reset.
    assign RX_TREADY = ARESET && (state_reg == IDLE || state_reg == COLLECT || state_reg == DISCARD);
    assign beat      = RX_TVALID && RX_TREADY;
    assign wr_idx    = (state_reg == IDLE) ? 16'd0 : byte_cnt_reg;

    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        wr_en      = 1'b0;
        hdr_en     = 1'b0;
        cnt_load   = 1'b0;
        cnt_inc    = 1'b0;
        drop_inc   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (beat) begin
                    wr_en    = 1'b1;
                    hdr_en   = 1'b1;
                    cnt_load = 1'b1;
                    if (RX_TLAST) begin
                        if (USER_DATA_BYTES == 1) begin
                            state_next = PENDING;
                        end else begin
                            drop_inc = 1'b1;
                        end
                    end else if (USER_DATA_BYTES == 1) begin
                        // A one-byte frame already full: anything more is oversize.
                        drop_inc   = 1'b1;
                        state_next = DISCARD;
                    end else begin
                        state_next = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (beat) begin
                    wr_en   = 1'b1;
                    cnt_inc = 1'b1;
                    if (RX_TLAST) begin
                        if (byte_cnt_reg == LAST_IDX) begin
                            state_next = PENDING;
                        end else begin
                            drop_inc   = 1'b1;
                            state_next = IDLE;
                        end
                    end else if (byte_cnt_reg == LAST_IDX) begin
                        drop_inc   = 1'b1;
                        state_next = DISCARD;
                    end
                end
            end
            DISCARD: begin
                if (beat && RX_TLAST) begin
                    state_next = IDLE;
                end
            end
            PENDING: begin
                if (!NN_BUSY) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            byte_cnt_reg  <= '0;
            frame_cnt_reg <= '0;
            drop_cnt_reg  <= '0;
            src_ip_reg    <= '0;
            src_mac_reg   <= '0;
            src_port_reg  <= '0;
        end else begin
            if (cnt_load) begin
                byte_cnt_reg <= 16'd1;
            end else if (cnt_inc) begin
                byte_cnt_reg <= byte_cnt_reg + 16'd1;
            end
            if (hdr_en) begin
                src_ip_reg   <= RX_SRC_IP;
                src_mac_reg  <= RX_SRC_MAC;
                src_port_reg <= RX_SRC_UDP_PORT;
            end
            if (state_reg == EMIT) begin
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
            end
            if (drop_inc && drop_cnt_reg != 16'hFFFF) begin
                drop_cnt_reg <= drop_cnt_reg + 16'd1;
            end
        end
    end

    // One register per frame byte; each decodes its own write strobe.
    genvar gi;
    generate
        for (gi = 0; gi < USER_DATA_BYTES; gi++) begin : g_byte
            logic [7:0] byte_reg;
            always_ff @(posedge ACLK or negedge ARESET) begin
                if (!ARESET) begin
                    byte_reg <= '0;
                end else if (wr_en && wr_idx == 16'(gi)) begin
                    byte_reg <= RX_TDATA;
                end
            end
            assign DATA_FRAME_IP[gi*8 +: 8] = byte_reg;
        end
    endgenerate

    assign SRC_IP_ADDRESS_IP  = src_ip_reg;
    assign SRC_MAC_ADDRESS_IP = src_mac_reg;
    assign SRC_UDP_PORT_IP    = src_port_reg;
    assign FRAME_READY        = (state_reg == EMIT);
    assign FRAME_COUNT        = frame_cnt_reg;
    assign DROP_COUNT         = drop_cnt_reg;

endmodule

// File: tb/tb_udp_rx_frame_assembler.sv
// Directed/randomized bench for udp_rx_frame_assembler; expectations come from a
// packet-level model (length classification, byte array copy, counters).
`timescale 1ns/1ps
module tb_udp_rx_frame_assembler;

    localparam int N = 784;

    logic            ACLK = 1'b0;
    logic            ARESET;
    logic [7:0]      RX_TDATA;
    logic            RX_TVALID;
    logic            RX_TLAST;
    logic            RX_TREADY;
    logic [31:0]     RX_SRC_IP;
    logic [47:0]     RX_SRC_MAC;
    logic [15:0]     RX_SRC_UDP_PORT;
    logic            NN_BUSY;
    logic [0:N*8-1]  DATA_FRAME_IP;
    logic [0:31]     SRC_IP_ADDRESS_IP;
    logic [0:47]     SRC_MAC_ADDRESS_IP;
    logic [0:15]     SRC_UDP_PORT_IP;
    logic            FRAME_READY;
    logic [15:0]     FRAME_COUNT;
    logic [15:0]     DROP_COUNT;

    udp_rx_frame_assembler #(.USER_DATA_BYTES(N)) dut (
        .ACLK               (ACLK),
        .ARESET             (ARESET),
        .RX_TDATA           (RX_TDATA),
        .RX_TVALID          (RX_TVALID),
        .RX_TLAST           (RX_TLAST),
        .RX_TREADY          (RX_TREADY),
        .RX_SRC_IP          (RX_SRC_IP),
        .RX_SRC_MAC         (RX_SRC_MAC),
        .RX_SRC_UDP_PORT    (RX_SRC_UDP_PORT),
        .NN_BUSY            (NN_BUSY),
        .DATA_FRAME_IP      (DATA_FRAME_IP),
        .SRC_IP_ADDRESS_IP  (SRC_IP_ADDRESS_IP),
        .SRC_MAC_ADDRESS_IP (SRC_MAC_ADDRESS_IP),
        .SRC_UDP_PORT_IP    (SRC_UDP_PORT_IP),
        .FRAME_READY        (FRAME_READY),
        .FRAME_COUNT        (FRAME_COUNT),
        .DROP_COUNT         (DROP_COUNT)
    );

    always #5 ACLK = ~ACLK;

    int total = 0;
    int bad   = 0;

    logic [7:0]  pkt [0:1023];
    logic [7:0]  exp_frame [0:N-1];
    logic [31:0] exp_ip;
    logic [47:0] exp_mac;
    logic [15:0] exp_port;
    int          exp_frames = 0;
    int          exp_drops  = 0;
    int          exp_pulses = 0;
    int          fr_pulses  = 0;
    int          st;

    always @(negedge ACLK) begin
        if (FRAME_READY === 1'b1) fr_pulses++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_frame(input string tag);
        int nbad = 0;
        int first = -1;
        logic [7:0] ob;
        for (int k = 0; k < N; k++) begin
            ob = DATA_FRAME_IP[k*8 +: 8];
            if (ob !== exp_frame[k]) begin
                if (first < 0) first = k;
                nbad++;
            end
        end
        total++;
        assert (nbad === 0) else begin
            bad++;
            $error("FAIL %s: %0d bytes differ, first index %0d observed=%02h expected=%02h",
                   tag, nbad, first, DATA_FRAME_IP[first*8 +: 8], exp_frame[first]);
        end
    endtask

    task automatic new_header();
        RX_SRC_IP       = $urandom;
        RX_SRC_MAC      = {16'($urandom), 32'($urandom)};
        RX_SRC_UDP_PORT = 16'($urandom);
    endtask

    // Drives pkt[first +: len]; called and returns at posedge+1.
    task automatic send_bytes(input int first, input int len, input bit last, input int duty,
                              output int stalls);
        bit ok;
        int guard;
        stalls = 0;
        for (int i = first; i < first + len; i++) begin
            while (duty < 100 && $urandom_range(99, 0) >= duty) begin
                RX_TVALID = 1'b0;
                RX_TDATA  = 'x;
                RX_TLAST  = 1'b0;
                @(posedge ACLK); #1;
            end
            RX_TVALID = 1'b1;
            RX_TDATA  = pkt[i];
            RX_TLAST  = last && (i == first + len - 1);
            guard = 0;
            do begin
                @(negedge ACLK);
                ok = RX_TREADY;
                if (!ok) begin
                    stalls++;
                    guard++;
                end
            end while (!ok && guard < 2000);
            if (!ok) begin
                check("rx_tready_timeout", 64'(ok), 64'd1);
                break;
            end
            @(posedge ACLK); #1;
        end
        RX_TVALID = 1'b0;
        RX_TDATA  = 'x;
        RX_TLAST  = 1'b0;
    endtask

    task automatic capture_expected();
        for (int k = 0; k < N; k++) exp_frame[k] = pkt[k];
        exp_ip   = RX_SRC_IP;
        exp_mac  = RX_SRC_MAC;
        exp_port = RX_SRC_UDP_PORT;
    endtask

    task automatic check_outputs_at_pulse(input string tag);
        check({tag, "_fr_pulse"}, 64'(FRAME_READY), 64'd1);
        check_frame({tag, "_frame"});
        check({tag, "_ip"}, 64'(SRC_IP_ADDRESS_IP), 64'(exp_ip));
        check({tag, "_mac"}, 64'(SRC_MAC_ADDRESS_IP), 64'(exp_mac));
        check({tag, "_port"}, 64'(SRC_UDP_PORT_IP), 64'(exp_port));
        exp_frames++;
        exp_pulses++;
    endtask

    task automatic after_pulse(input string tag);
        @(negedge ACLK);
        check({tag, "_fr_single"}, 64'(FRAME_READY), 64'd0);
        check({tag, "_frame_count"}, 64'(FRAME_COUNT), 64'(exp_frames));
        check({tag, "_drop_count"}, 64'(DROP_COUNT), 64'(exp_drops));
        check({tag, "_pulses"}, 64'(fr_pulses), 64'(exp_pulses));
        @(posedge ACLK); #1;
    endtask

    // Sends pkt[0:N-1] with the current header and expects delivery at TLAST+2.
    task automatic good_packet(input string tag, input int duty);
        capture_expected();
        send_bytes(0, N, 1'b1, duty, st);
        @(negedge ACLK);
        check({tag, "_fr_early"}, 64'(FRAME_READY), 64'd0);
        @(negedge ACLK);
        check_outputs_at_pulse(tag);
        after_pulse(tag);
    endtask

    initial begin
        ARESET          = 1'b0;
        RX_TDATA        = 'x;
        RX_TVALID       = 1'b0;
        RX_TLAST        = 1'b0;
        NN_BUSY         = 1'b0;
        RX_SRC_IP       = '0;
        RX_SRC_MAC      = '0;
        RX_SRC_UDP_PORT = '0;

        // Reset state
        #2;
        check("rst_tready", 64'(RX_TREADY), 64'd0);
        check("rst_fr", 64'(FRAME_READY), 64'd0);
        check("rst_frame_count", 64'(FRAME_COUNT), 64'd0);
        check("rst_drop_count", 64'(DROP_COUNT), 64'd0);
        check("rst_ip", 64'(SRC_IP_ADDRESS_IP), 64'd0);
        for (int k = 0; k < N; k++) exp_frame[k] = 8'h00;
        check_frame("rst_frame");
        repeat (3) @(posedge ACLK);
        #1 ARESET = 1'b1;
        @(negedge ACLK);
        check("idle_tready", 64'(RX_TREADY), 64'd1);
        @(posedge ACLK); #1;

        // Nominal
        for (int k = 0; k < N; k++) pkt[k] = 8'(k);
        RX_SRC_IP       = 32'h0A000001;
        RX_SRC_MAC      = 48'h0211_2233_4455;
        RX_SRC_UDP_PORT = 16'h1F90;
        good_packet("nominal", 100);
        check("nominal_byte0", 64'(DATA_FRAME_IP[0:7]), 64'h00);
        check("nominal_byte1", 64'(DATA_FRAME_IP[8:15]), 64'h01);
        check("nominal_byte783", 64'(DATA_FRAME_IP[6264:6271]), 64'h0F);

        // Backpressure with a second packet queued behind the held frame
        for (int k = 0; k < N; k++) pkt[k] = 8'($urandom);
        new_header();
        NN_BUSY = 1'b1;
        capture_expected();
        send_bytes(0, N, 1'b1, 100, st);
        RX_TVALID = 1'b1;
        RX_TDATA  = 8'hA5;
        for (int c = 0; c < 20; c++) begin
            @(negedge ACLK);
            check($sformatf("bp_hold_tready_%0d", c), 64'(RX_TREADY), 64'd0);
            check($sformatf("bp_hold_fr_%0d", c), 64'(FRAME_READY), 64'd0);
            @(posedge ACLK); #1;
        end
        NN_BUSY = 1'b0;
        @(negedge ACLK);
        check("bp_release_fr_early", 64'(FRAME_READY), 64'd0);
        check("bp_release_tready", 64'(RX_TREADY), 64'd0);
        @(negedge ACLK);
        check("bp_emit_tready", 64'(RX_TREADY), 64'd0);
        check_outputs_at_pulse("bp");
        @(posedge ACLK); #1;
        pkt[0] = 8'hA5;
        for (int k = 1; k < N; k++) pkt[k] = 8'($urandom);
        new_header();
        capture_expected();
        send_bytes(0, N, 1'b1, 100, st);
        check("bp_queued_stalls", 64'(st), 64'd0);
        @(negedge ACLK);
        @(negedge ACLK);
        check_outputs_at_pulse("bp_queued");
        after_pulse("bp_queued");

        // Short packet, then a good one with its own header
        for (int k = 0; k < 100; k++) pkt[k] = 8'($urandom);
        new_header();
        send_bytes(0, 100, 1'b1, 100, st);
        exp_drops++;
        repeat (3) @(negedge ACLK);
        check("short_drop_count", 64'(DROP_COUNT), 64'(exp_drops));
        check("short_pulses", 64'(fr_pulses), 64'(exp_pulses));
        check("short_tready", 64'(RX_TREADY), 64'd1);
        @(posedge ACLK); #1;
        for (int k = 0; k < N; k++) pkt[k] = 8'($urandom);
        new_header();
        good_packet("after_short", 100);

        // Oversize packet: 784 bytes then 16 more before TLAST
        for (int k = 0; k < 800; k++) pkt[k] = 8'($urandom);
        new_header();
        send_bytes(0, N, 1'b0, 100, st);
        exp_drops++;
        @(negedge ACLK);
        check("over_drop_at_783", 64'(DROP_COUNT), 64'(exp_drops));
        check("over_discard_tready", 64'(RX_TREADY), 64'd1);
        @(posedge ACLK); #1;
        send_bytes(N, 16, 1'b1, 100, st);
        check("over_tail_stalls", 64'(st), 64'd0);
        repeat (3) @(negedge ACLK);
        check("over_pulses", 64'(fr_pulses), 64'(exp_pulses));
        check("over_drop_final", 64'(DROP_COUNT), 64'(exp_drops));
        @(posedge ACLK); #1;
        for (int k = 0; k < N; k++) pkt[k] = 8'($urandom);
        new_header();
        good_packet("after_over", 100);

        // Gapped input, same contents as nominal
        for (int k = 0; k < N; k++) pkt[k] = 8'(k);
        RX_SRC_IP       = 32'h0A000001;
        RX_SRC_MAC      = 48'h0211_2233_4455;
        RX_SRC_UDP_PORT = 16'h1F90;
        good_packet("gapped", 50);

        // Reset mid-packet
        for (int k = 0; k < N; k++) pkt[k] = 8'($urandom);
        new_header();
        send_bytes(0, 400, 1'b0, 100, st);
        ARESET = 1'b0;
        #1;
        check("midrst_tready", 64'(RX_TREADY), 64'd0);
        check("midrst_fr", 64'(FRAME_READY), 64'd0);
        check("midrst_frame_count", 64'(FRAME_COUNT), 64'd0);
        check("midrst_drop_count", 64'(DROP_COUNT), 64'd0);
        check("midrst_port", 64'(SRC_UDP_PORT_IP), 64'd0);
        for (int k = 0; k < N; k++) exp_frame[k] = 8'h00;
        check_frame("midrst_frame");
        exp_frames = 0;
        exp_drops  = 0;
        repeat (2) @(posedge ACLK);
        #1 ARESET = 1'b1;
        check("midrst_pulses", 64'(fr_pulses), 64'(exp_pulses));
        for (int k = 0; k < N; k++) pkt[k] = 8'($urandom);
        new_header();
        good_packet("post_rst", 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
